// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the sequence feeder and the blocks around it:
// the default word width, the bit-index width helper, and the bit
// positions of the sticky error flags (reused by the status register).
// ---------------------------------------------------------------------------
package seq_pkg;

    localparam int DATA_W_DEF = 8;

    // Bit positions of the error flags inside an error vector
    localparam int ERR_OVF = 0;
    localparam int ERR_ACK = 1;

    // Width of an index that selects one bit of a DATA_W-wide word.
    // A single-bit word still gets a one-bit index so ports never collapse.
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/seq_feeder_fifo.sv
// ---------------------------------------------------------------------------
// seq_feeder_fifo
// Single-clock synchronous FIFO feeding the serialiser.
// Ports:
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   push         write request; push_data is the word to store
//   pop          retire request for the head word
//   full, empty  occupancy flags decoded from the registered count
//   count        occupancy, 0..DEPTH
//   head         word at the read pointer
// A push while full is accepted only if a pop retires a word on the same
// edge, so the freed slot is reused immediately and count stays put.
// ---------------------------------------------------------------------------
module seq_feeder_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage carries no reset; stale contents are never observed because
    // the consumer only looks at head while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/seq_feeder.sv
// ---------------------------------------------------------------------------
// seq_feeder
// Buffers host words and presents the head word as an MSB-first bit stream
// to the sequence control block.
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   wr_en, wr_data  host write strobe and word
//   full, empty     FIFO occupancy flags
//   count           FIFO occupancy, 0..DEPTH
//   data_ack        one-cycle pulse retiring the head word
//   seq_rdy         head word valid and being serialised
//   ser_bit         current serial bit; bit_idx is its position (0 = MSB)
//   ovf_err         sticky: write attempted while full and nothing popped
//   ack_err         sticky: data_ack seen while empty
// Every output is derived from registers only.
// ---------------------------------------------------------------------------
module seq_feeder
    import seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        full,
    output logic                        empty,
    output logic [CNT_W-1:0]            count,
    input  logic                        data_ack,
    output logic                        seq_rdy,
    output logic                        ser_bit,
    output logic [idx_w(DATA_W)-1:0]    bit_idx,
    output logic                        ovf_err,
    output logic                        ack_err
);

    localparam int IDX_W = idx_w(DATA_W);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] shifted;
    logic              pop_ok;
    logic [1:0]        err_q;

    seq_feeder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (data_ack),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    assign pop_ok  = data_ack && !empty;
    assign seq_rdy = !empty;

    // Frame position: restarts at the MSB after every pop and while idle,
    // otherwise walks the word and wraps so an unacked word repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= '0;
        end else if (pop_ok || empty) begin
            bit_idx <= '0;
        end else if (bit_idx == IDX_W'(DATA_W - 1)) begin
            bit_idx <= '0;
        end else begin
            bit_idx <= bit_idx + IDX_W'(1);
        end
    end

    // Shifting left by bit_idx brings bit DATA_W-1-bit_idx to the top.
    assign shifted = head << bit_idx;
    assign ser_bit = seq_rdy & shifted[DATA_W-1];

    // A write while full is only an overflow when no pop frees a slot on
    // the same edge (full implies non-empty, so any ack is a real pop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            if (wr_en && full && !data_ack) begin
                err_q[ERR_OVF] <= 1'b1;
            end
            if (data_ack && empty) begin
                err_q[ERR_ACK] <= 1'b1;
            end
        end
    end

    assign ovf_err = err_q[ERR_OVF];
    assign ack_err = err_q[ERR_ACK];

endmodule

// File: tb/tb_seq_feeder.sv
// ---------------------------------------------------------------------------
// tb_seq_feeder
// Self-checking bench for seq_feeder (DATA_W=8, DEPTH=4).
// The stimulus process drives directed vectors and pushes every word it
// expects the FIFO to accept into a scoreboard queue. A separate monitor
// samples on the falling edge and checks the serial stream against the
// head of that queue, retiring entries when the bench acks them.
// ---------------------------------------------------------------------------
module tb_seq_feeder;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       data_ack;
    logic       seq_rdy;
    logic       ser_bit;
    logic [2:0] bit_idx;
    logic       ovf_err;
    logic       ack_err;

    int checks;
    int errors;

    logic [7:0] exp_q[$];
    int         m_idx;
    logic       mon_en;

    seq_feeder #(
        .DATA_W (8),
        .DEPTH  (4),
        .CNT_W  (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .data_ack (data_ack),
        .seq_rdy  (seq_rdy),
        .ser_bit  (ser_bit),
        .bit_idx  (bit_idx),
        .ovf_err  (ovf_err),
        .ack_err  (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs; accepted words enter the scoreboard
    // after the edge that stores them
    task automatic applyStimulus(input logic we, input logic [7:0] d,
                                 input logic ack, input logic accept);
        wr_en    = we;
        wr_data  = d;
        data_ack = ack;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        data_ack = 1'b0;
        if (accept) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    // Bounded wait until the DUT reaches a given frame position
    task automatic waitIdx(input int target, input string name);
        int n;
        n = 0;
        while (int'(bit_idx) != target && n < 20) begin
            idle(1);
            n++;
        end
        checkOutput(name, int'(bit_idx), target);
    endtask

    // Scoreboard monitor: checks the stream, then advances its model
    // using the inputs being applied during this cycle
    always @(negedge clk) begin
        logic [7:0] w;
        if (mon_en && rst_n) begin
            if (exp_q.size() > 0) begin
                w = exp_q[0];
                checkOutput("mon_seq_rdy", int'(seq_rdy), 1);
                checkOutput("mon_bit_idx", int'(bit_idx), m_idx);
                checkOutput("mon_ser_bit", int'(ser_bit), int'(w[7 - m_idx]));
                if (data_ack) begin
                    void'(exp_q.pop_front());
                    m_idx = 0;
                end else begin
                    m_idx = (m_idx == 7) ? 0 : m_idx + 1;
                end
            end else begin
                checkOutput("mon_idle_rdy", int'(seq_rdy), 0);
                checkOutput("mon_idle_bit", int'(ser_bit), 0);
                m_idx = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        m_idx    = 0;
        mon_en   = 1'b0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        data_ack = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(5);
        checkOutput("rst_empty", int'(empty), 1);
        checkOutput("rst_seq_rdy", int'(seq_rdy), 0);
        checkOutput("rst_count", int'(count), 0);
        checkOutput("rst_ser_bit", int'(ser_bit), 0);
        checkOutput("rst_ovf", int'(ovf_err), 0);
        checkOutput("rst_ack", int'(ack_err), 0);

        // Single word, no ack: visible next cycle and repeating
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b1);
        checkOutput("a5_seq_rdy", int'(seq_rdy), 1);
        checkOutput("a5_first_bit", int'(ser_bit), 1);
        checkOutput("a5_count", int'(count), 1);
        idle(10);

        // Second word, ack at end of frame
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1);
        waitIdx(7, "wait_idx7");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("ack7_bit_idx", int'(bit_idx), 0);
        checkOutput("ack7_count", int'(count), 1);
        checkOutput("ack7_ser_bit", int'(ser_bit), 0);
        idle(8);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("drain_empty", int'(empty), 1);
        checkOutput("drain_seq_rdy", int'(seq_rdy), 0);

        // Fill past DEPTH, then write+ack while full
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b1);
        checkOutput("fill_full", int'(full), 1);
        checkOutput("fill_count", int'(count), 4);
        checkOutput("fill_ovf_clear", int'(ovf_err), 0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        checkOutput("ovf_set", int'(ovf_err), 1);
        checkOutput("ovf_count", int'(count), 4);
        applyStimulus(1'b1, 8'h66, 1'b1, 1'b1);
        checkOutput("wrack_count", int'(count), 4);
        checkOutput("wrack_full", int'(full), 1);
        checkOutput("wrack_bit_idx", int'(bit_idx), 0);
        for (int i = 0; i < 4; i++) begin
            idle(2);
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checkOutput("fill_drain_empty", int'(empty), 1);

        // Ack while empty, then partial-frame ack
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("ackerr_set", int'(ack_err), 1);
        checkOutput("ackerr_count", int'(count), 0);
        applyStimulus(1'b1, 8'h5A, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1);
        waitIdx(3, "wait_idx3");
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("partial_bit_idx", int'(bit_idx), 0);
        checkOutput("partial_count", int'(count), 1);
        checkOutput("partial_msb", int'(ser_bit), 1);
        idle(4);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Write plus ack while empty: write lands, ack is an error
        applyStimulus(1'b1, 8'h81, 1'b1, 1'b1);
        checkOutput("wrempty_count", int'(count), 1);
        checkOutput("wrempty_ackerr", int'(ack_err), 1);

        // Asynchronous reset mid-frame with three words buffered
        applyStimulus(1'b1, 8'h96, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h0F, 1'b0, 1'b1);
        idle(2);
        checkOutput("pre_rst_count", int'(count), 3);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("arst_count", int'(count), 0);
        checkOutput("arst_empty", int'(empty), 1);
        checkOutput("arst_full", int'(full), 0);
        checkOutput("arst_seq_rdy", int'(seq_rdy), 0);
        checkOutput("arst_ser_bit", int'(ser_bit), 0);
        checkOutput("arst_bit_idx", int'(bit_idx), 0);
        checkOutput("arst_ovf", int'(ovf_err), 0);
        checkOutput("arst_ack", int'(ack_err), 0);
        exp_q.delete();
        m_idx = 0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Normal streaming after reset
        applyStimulus(1'b1, 8'hE7, 1'b0, 1'b1);
        checkOutput("post_rst_count", int'(count), 1);
        idle(10);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("post_rst_empty", int'(empty), 1);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
